// File: rtl/patbuf_ptr_sched_pkg.sv
// Shared definitions for the pattern-buffer pointer scheduler: geometry defaults,
// command opcodes and the scheduler state encoding.
package patbuf_pkg;

    localparam int BUF_COUNT    = 8;
    localparam int BUFFER_SIZE  = 32;
    localparam int BUFFER_WIDTH = 8;
    localparam int BUFP_W       = $clog2(BUF_COUNT);
    localparam int FIELDP_W     = $clog2(BUFFER_SIZE);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_SEEK   = 3'd1;
    localparam logic [2:0] OP_NEXT   = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_WRITE  = 3'd4;
    localparam logic [2:0] OP_SELBUF = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READ   = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

endpackage

// File: rtl/patbuf_ptr_sched_if.sv
// Processor command/response and loader swap channels of the pointer scheduler.
// The master side is the processor core plus serial loader; the slave side is the scheduler.
interface patbuf_ptr_sched_if #(
    parameter int BUFFER_WIDTH = patbuf_pkg::BUFFER_WIDTH,
    parameter int BUFP_W       = patbuf_pkg::BUFP_W,
    parameter int FIELDP_W     = patbuf_pkg::FIELDP_W
);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2:0]              cmd_op;
    logic [FIELDP_W-1:0]     cmd_arg;
    logic [BUFFER_WIDTH-1:0] cmd_wdata;
    logic                    rsp_valid;
    logic [BUFFER_WIDTH-1:0] rsp_data;
    logic                    swap_req;
    logic [BUFP_W-1:0]       swap_buf;
    logic                    swap_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_wdata, swap_req, swap_buf,
        input  cmd_ready, rsp_valid, rsp_data, swap_ack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_wdata, swap_req, swap_buf,
        output cmd_ready, rsp_valid, rsp_data, swap_ack
    );

endinterface

// File: rtl/patbuf_ptr_sched.sv
// Pattern-buffer pointer scheduler: owns bufp/fieldp, turns processor commands into
// field read/write cycles and arbitrates loader buffer swaps against them.
module patbuf_ptr_sched #(
    parameter int  BUF_COUNT    = patbuf_pkg::BUF_COUNT,
    parameter int  BUFFER_SIZE  = patbuf_pkg::BUFFER_SIZE,
    parameter int  BUFFER_WIDTH = patbuf_pkg::BUFFER_WIDTH,
    localparam int BUFP_W       = $clog2(BUF_COUNT),
    localparam int FIELDP_W     = $clog2(BUFFER_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    patbuf_ptr_sched_if.slave       bus,
    output logic [BUFP_W-1:0]       bufp,
    output logic [FIELDP_W-1:0]     fieldp,
    input  logic [BUFFER_WIDTH-1:0] field_byte,
    output logic [BUFFER_WIDTH-1:0] field_in,
    output logic                    field_write,
    output logic                    err
);

    import patbuf_pkg::*;

    state_e                  state_q, state_d;
    logic [BUFP_W-1:0]       bufp_q, bufp_d;
    logic [FIELDP_W-1:0]     fieldp_q, fieldp_d;
    logic [BUFFER_WIDTH-1:0] field_in_q, field_in_d;
    logic                    field_write_q, field_write_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [BUFFER_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    swap_ack_q, swap_ack_d;
    logic                    err_q, err_d;
    logic                    cmd_ready_s;

    // Next-state and command decode; only one pointer can move per accepted action.
    always_comb begin
        state_d       = state_q;
        bufp_d        = bufp_q;
        fieldp_d      = fieldp_q;
        field_in_d    = field_in_q;
        field_write_d = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        swap_ack_d    = 1'b0;
        err_d         = err_q;
        cmd_ready_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.swap_req) begin
                    bufp_d     = bus.swap_buf;
                    swap_ack_d = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    cmd_ready_s = 1'b1;
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_NOP:  state_d = ST_IDLE;
                            OP_SEEK: fieldp_d = bus.cmd_arg;
                            OP_NEXT: begin
                                if (fieldp_q == FIELDP_W'(BUFFER_SIZE - 1)) begin
                                    fieldp_d = '0;
                                end else begin
                                    fieldp_d = fieldp_q + FIELDP_W'(1);
                                end
                            end
                            OP_READ: state_d = ST_READ;
                            OP_WRITE: begin
                                field_in_d    = bus.cmd_wdata;
                                field_write_d = 1'b1;
                                state_d       = ST_WRITE;
                            end
                            OP_SELBUF: begin
                                bufp_d  = bus.cmd_arg[BUFP_W-1:0];
                                state_d = ST_SETTLE;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SETTLE: state_d = ST_IDLE;
            ST_READ: begin
                rsp_data_d  = field_byte;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bufp_q        <= '0;
            fieldp_q      <= '0;
            field_in_q    <= '0;
            field_write_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            swap_ack_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bufp_q        <= bufp_d;
            fieldp_q      <= fieldp_d;
            field_in_q    <= field_in_d;
            field_write_q <= field_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            swap_ack_q    <= swap_ack_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.swap_ack  = swap_ack_q;
    assign bufp          = bufp_q;
    assign fieldp        = fieldp_q;
    assign field_in      = field_in_q;
    assign field_write   = field_write_q;
    assign err           = err_q;

endmodule

// File: tb/tb_patbuf_ptr_sched.sv
// Self-checking bench for patbuf_ptr_sched: directed scenarios plus random commands
// compared against a pointer/buffer-contents reference model.
module tb_patbuf_ptr_sched;
    import patbuf_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [7:0] field_byte;
    logic [7:0] field_in;
    logic       field_write;
    logic       err;

    patbuf_ptr_sched_if bus ();

    patbuf_ptr_sched dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bufp       (bufp),
        .fieldp     (fieldp),
        .field_byte (field_byte),
        .field_in   (field_in),
        .field_write(field_write),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Buffers block stand-in: unwritten fields read as a fixed pattern.
    logic [7:0] env_mem [8][32];
    logic       env_wr  [8][32];
    logic       ovr_en;
    logic [7:0] ovr_byte;

    function automatic logic [7:0] init_byte(input int b, input int f);
        return 8'((b * 37 + f * 11 + 5) & 255);
    endfunction

    assign field_byte = ovr_en ? ovr_byte :
                        (env_wr[bufp][fieldp] ? env_mem[bufp][fieldp] : init_byte(int'(bufp), int'(fieldp)));

    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 8; b++)
                for (int f = 0; f < 32; f++)
                    env_wr[b][f] <= 1'b0;
        end else if (field_write) begin
            env_mem[bufp][fieldp] <= field_in;
            env_wr[bufp][fieldp]  <= 1'b1;
        end
    end

    // Pointer monitor: counts cycles in which both pointers moved outside reset.
    logic       rst_edge;
    logic [2:0] prev_b;
    logic [4:0] prev_f;
    int         viol = 0;
    always @(posedge clk) rst_edge <= rst;
    always @(negedge clk) begin
        if (rst_edge === 1'b0 && bufp !== prev_b && fieldp !== prev_f) viol <= viol + 1;
        prev_b <= bufp;
        prev_f <= fieldp;
    end

    // Reference model state.
    int         m_bufp, m_fieldp;
    bit         m_err;
    logic [7:0] ref_mem [8][32];

    task automatic ref_reset();
        m_bufp = 0; m_fieldp = 0; m_err = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int f = 0; f < 32; f++)
                ref_mem[b][f] = init_byte(b, f);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present a command; returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input logic [4:0] arg, input logic [7:0] wd);
        int n;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg; bus.cmd_wdata = wd;
        #1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 30) begin
            @(posedge clk); #2; n++;
        end
        n_checks++;
        if (n >= 30) $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 30 cycles", bus.cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = 5'd0; bus.cmd_wdata = 8'd0;
    endtask

    task automatic swap_task(input logic [2:0] sb);
        int n;
        bus.swap_req = 1'b1; bus.swap_buf = sb;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (bus.swap_ack !== 1'b1 && n < 30);
        n_checks++;
        if (bus.swap_ack !== 1'b1) $display("FAIL swap_ack_wait: swap_ack=%b, required 1 within 30 cycles", bus.swap_ack);
        else n_pass++;
        bus.swap_req = 1'b0;
    endtask

    task automatic test_reset();
        send_cmd(OP_SEEK, 5'd13, 8'd0);   tick();
        send_cmd(OP_SELBUF, 5'd3, 8'd0);  tick();
        send_cmd(OP_WRITE, 5'd0, 8'h77);  tick();
        ovr_en = 1'b1; ovr_byte = 8'hEE;
        send_cmd(OP_READ, 5'd0, 8'd0);    tick();
        ovr_en = 1'b0;
        send_cmd(3'd7, 5'd0, 8'd0);       tick();
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_wdata = 8'hFF;
        bus.swap_req = 1'b1; bus.swap_buf = 3'd7;
        rst = 1'b1;
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_wdata = 8'd0; bus.swap_req = 1'b0;
        rst = 1'b0;
        n_checks++; if (bufp !== 3'd0) $display("FAIL reset_bufp: got %0d required 0", bufp); else n_pass++;
        n_checks++; if (fieldp !== 5'd0) $display("FAIL reset_fieldp: got %0d required 0", fieldp); else n_pass++;
        n_checks++; if (field_write !== 1'b0 || field_in !== 8'd0)
            $display("FAIL reset_field_out: got we=%b in=%h required 0/00", field_write, field_in); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'd0)
            $display("FAIL reset_rsp: got v=%b d=%h required 0/00", bus.rsp_valid, bus.rsp_data); else n_pass++;
        n_checks++; if (bus.swap_ack !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_ack_err: got ack=%b err=%b required 0/0", bus.swap_ack, err); else n_pass++;
        tick();
    endtask

    task automatic test_seek_next_read();
        send_cmd(OP_SEEK, 5'd31, 8'd0);
        n_checks++; if (fieldp !== 5'd31) $display("FAIL seek31: got %0d required 31", fieldp); else n_pass++;
        tick();
        send_cmd(OP_NEXT, 5'd0, 8'd0);
        n_checks++; if (fieldp !== 5'd0) $display("FAIL next_wrap: got %0d required 0", fieldp); else n_pass++;
        tick();
        ovr_en = 1'b1; ovr_byte = 8'hA5;
        send_cmd(OP_READ, 5'd0, 8'd0);
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL read_t1_valid: got %b required 0", bus.rsp_valid); else n_pass++;
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hA5)
            $display("FAIL read_t2: got v=%b d=%h required 1/a5", bus.rsp_valid, bus.rsp_data); else n_pass++;
        ovr_byte = 8'h00;
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'hA5)
            $display("FAIL read_t3_hold: got v=%b d=%h required 0/a5", bus.rsp_valid, bus.rsp_data); else n_pass++;
        ovr_en = 1'b0;
    endtask

    task automatic test_write();
        send_cmd(OP_SEEK, 5'd7, 8'd0);
        tick();
        send_cmd(OP_WRITE, 5'd0, 8'h3C);
        n_checks++; if (field_write !== 1'b1 || field_in !== 8'h3C || fieldp !== 5'd7 || bus.cmd_ready !== 1'b0)
            $display("FAIL write_t1: got we=%b in=%h fp=%0d rdy=%b required 1/3c/7/0",
                     field_write, field_in, fieldp, bus.cmd_ready); else n_pass++;
        tick();
        n_checks++; if (field_write !== 1'b0 || fieldp !== 5'd7 || bus.cmd_ready !== 1'b1)
            $display("FAIL write_t2: got we=%b fp=%0d rdy=%b required 0/7/1",
                     field_write, fieldp, bus.cmd_ready); else n_pass++;
    endtask

    task automatic test_swap_vs_cmd();
        bus.swap_req = 1'b1; bus.swap_buf = 3'd5;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_SEEK; bus.cmd_arg = 5'd9;
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL swapcmd_ready_grant: got %b required 0", bus.cmd_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bufp !== 3'd5 || bus.swap_ack !== 1'b1 || fieldp !== 5'd7)
            $display("FAIL swapcmd_grant: got bufp=%0d ack=%b fp=%0d required 5/1/7",
                     bufp, bus.swap_ack, fieldp); else n_pass++;
        bus.swap_req = 1'b0;
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL swapcmd_settle_ready: got %b required 0", bus.cmd_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.swap_ack !== 1'b0 || fieldp !== 5'd7)
            $display("FAIL swapcmd_settle: got ack=%b fp=%0d required 0/7", bus.swap_ack, fieldp); else n_pass++;
        #1;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL swapcmd_idle_ready: got %b required 1", bus.cmd_ready); else n_pass++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = 5'd0;
        n_checks++; if (fieldp !== 5'd9 || bufp !== 3'd5)
            $display("FAIL swapcmd_seek: got fp=%0d bufp=%0d required 9/5", fieldp, bufp); else n_pass++;
        tick();
    endtask

    task automatic test_swap_during_read();
        ovr_en = 1'b1; ovr_byte = 8'h5A;
        send_cmd(OP_READ, 5'd0, 8'd0);
        bus.swap_req = 1'b1; bus.swap_buf = 3'd2;
        @(posedge clk); #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.swap_ack !== 1'b0 || bufp !== 3'd5)
            $display("FAIL swapread_rsp: got v=%b d=%h ack=%b bufp=%0d required 1/5a/0/5",
                     bus.rsp_valid, bus.rsp_data, bus.swap_ack, bufp); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.swap_ack !== 1'b1 || bufp !== 3'd2 || bus.rsp_valid !== 1'b0)
            $display("FAIL swapread_ack: got ack=%b bufp=%0d v=%b required 1/2/0",
                     bus.swap_ack, bufp, bus.rsp_valid); else n_pass++;
        bus.swap_req = 1'b0;
        ovr_en = 1'b0;
        tick();
    endtask

    task automatic test_swap_drop();
        int acks;
        send_cmd(OP_WRITE, 5'd0, 8'h11);
        bus.swap_req = 1'b1; bus.swap_buf = 3'd6;
        @(posedge clk); #1;
        bus.swap_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.swap_ack === 1'b1) acks++;
            tick();
        end
        n_checks++; if (acks != 0 || bufp !== 3'd2)
            $display("FAIL swap_drop: got acks=%0d bufp=%0d required 0/2", acks, bufp); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [2:0] b0;
        logic [4:0] f0;
        b0 = bufp; f0 = fieldp;
        send_cmd(3'd7, 5'd17, 8'd0);
        n_checks++; if (err !== 1'b1 || bufp !== b0 || fieldp !== f0)
            $display("FAIL illegal7: got err=%b bufp=%0d fp=%0d required 1/%0d/%0d", err, bufp, fieldp, b0, f0); else n_pass++;
        tick();
        send_cmd(OP_NOP, 5'd0, 8'd0); tick();
        send_cmd(3'd6, 5'd3, 8'd0);   tick();
        n_checks++; if (err !== 1'b1 || bufp !== b0 || fieldp !== f0)
            $display("FAIL illegal_sticky: got err=%b bufp=%0d fp=%0d required 1/%0d/%0d", err, bufp, fieldp, b0, f0); else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (err !== 1'b0) $display("FAIL illegal_clear: got err=%b required 0", err); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [4:0] arg;
        logic [7:0] wd, exp_rd;
        logic [2:0] sb;
        int r;
        rst = 1'b1; tick(); rst = 1'b0;
        ref_reset();
        exp_rd = 8'd0;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      op = OP_NOP;
            else if (r < 25) op = OP_SEEK;
            else if (r < 40) op = OP_NEXT;
            else if (r < 60) op = OP_READ;
            else if (r < 80) op = OP_WRITE;
            else if (r < 93) op = OP_SELBUF;
            else             op = 3'($urandom_range(6, 7));
            arg = 5'($urandom_range(0, 31));
            wd  = 8'($urandom_range(0, 255));
            sb  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                fork
                    swap_task(sb);
                    send_cmd(op, arg, wd);
                join
                m_bufp = int'(sb);
            end else begin
                send_cmd(op, arg, wd);
            end
            case (op)
                OP_SEEK:   m_fieldp = int'(arg);
                OP_NEXT:   m_fieldp = (m_fieldp + 1) % 32;
                OP_READ:   exp_rd = ref_mem[m_bufp][m_fieldp];
                OP_WRITE:  ref_mem[m_bufp][m_fieldp] = wd;
                OP_SELBUF: m_bufp = int'(arg) % 8;
                3'd6, 3'd7: m_err = 1'b1;
                default: ;
            endcase
            if (op == OP_WRITE) begin
                n_checks++; if (field_write !== 1'b1 || field_in !== wd)
                    $display("FAIL rnd_write[%0d]: got we=%b in=%h required 1/%h", i, field_write, field_in, wd); else n_pass++;
            end
            tick();
            n_checks++; if (bus.rsp_valid !== (op == OP_READ))
                $display("FAIL rnd_rsp_valid[%0d]: got %b required %b", i, bus.rsp_valid, op == OP_READ); else n_pass++;
            if (op == OP_READ) begin
                n_checks++; if (bus.rsp_data !== exp_rd)
                    $display("FAIL rnd_rsp_data[%0d]: got %h required %h", i, bus.rsp_data, exp_rd); else n_pass++;
            end
            n_checks++; if (bufp !== 3'(m_bufp) || fieldp !== 5'(m_fieldp) || err !== m_err)
                $display("FAIL rnd_state[%0d]: got b=%0d f=%0d e=%b required %0d/%0d/%b",
                         i, bufp, fieldp, err, m_bufp, m_fieldp, m_err); else n_pass++;
        end
        n_checks++; if (viol != 0) $display("FAIL ptr_invariant: got %0d simultaneous changes required 0", viol); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ovr_en = 1'b0; ovr_byte = 8'd0;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = 5'd0; bus.cmd_wdata = 8'd0;
        bus.swap_req = 1'b0; bus.swap_buf = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        test_reset();
        test_seek_next_read();
        test_write();
        test_swap_vs_cmd();
        test_swap_during_read();
        test_swap_drop();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/patbuf_ptr_sched.md
Name: patbuf_ptr_sched

Overview:
Sequences the pattern-buffer array: owns the buffer pointer (bufp) and field pointer (fieldp), and turns pattern-processor commands into field read/write cycles. Arbitrates buffer-switch requests from the serial loader against processor commands. Guarantees bufp and fieldp never change in the same clock cycle. Sits between the processor core and the buffers block, in the clk domain.

Parameters:
BUF_COUNT, 8, number of pattern buffers; bufp width = clog2(BUF_COUNT) = 3
BUFFER_SIZE, 32, fields per buffer; fieldp width = clog2(BUFFER_SIZE) = 5
BUFFER_WIDTH, 8, bits per field

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  processor command valid
cmd_ready  out  1  scheduler accepts command this cycle (valid&ready = accept)
cmd_op  in  3  0 NOP, 1 SEEK (fieldp=arg), 2 NEXT (fieldp+1), 3 READ, 4 WRITE, 5 SELBUF (bufp=arg[2:0]), 6/7 illegal
cmd_arg  in  5  field index or buffer index
cmd_wdata  in  BUFFER_WIDTH  write data for WRITE
rsp_valid  out  1  one-cycle pulse, READ data valid
rsp_data  out  BUFFER_WIDTH  READ result, held until next READ response
swap_req  in  1  loader requests switch to buffer swap_buf (level, held until ack)
swap_buf  in  3  target buffer for swap
swap_ack  out  1  one-cycle pulse when bufp has taken swap_buf
bufp  out  3  buffer pointer to buffers block (registered)
fieldp  out  5  field pointer to buffers block (registered)
field_byte  in  BUFFER_WIDTH  field currently addressed by bufp/fieldp
field_in  out  BUFFER_WIDTH  write data to buffers (registered)
field_write  out  1  write strobe to buffers (registered, one cycle)
err  out  1  sticky: illegal op accepted; cleared only by rst

Behaviour:
- Reset (rst high at posedge): bufp=0, fieldp=0, field_in=0, field_write=0, rsp_valid=0, rsp_data=0, swap_ack=0, err=0, state=IDLE. rst mid-operation aborts any command; no response is issued for it.
- FSM states: IDLE, SETTLE, READ, WRITE.
- cmd_ready=1 only in IDLE and only when no swap is being granted that cycle.
- IDLE arbitration: swap_req has priority over cmd_valid. On grant: bufp<=swap_buf, swap_ack pulses the same cycle the register updates, next state SETTLE. The processor command waits (cmd_ready=0).
- SEEK: fieldp<=arg, state IDLE; 1-cycle op.
- NEXT: fieldp<=fieldp+1 modulo BUFFER_SIZE (31 wraps to 0), state IDLE.
- SELBUF: bufp<=arg[2:0], next state SETTLE (fieldp unchanged).
- SETTLE: one dead cycle after any bufp change; no pointer update, cmd_ready=0; goes to IDLE.
- READ (accepted cycle T): next state READ. In state READ (T+1), rsp_data<=field_byte and rsp_valid=1 at T+2, back to IDLE. Pointers do not change during the READ.
- WRITE (accepted T): field_in<=cmd_wdata, field_write=1 for exactly one cycle (T+1), state WRITE, IDLE at T+2. The buffers block captures the write one stage later, so the scheduler holds pointers stable through T+2 (WRITE state plus the following IDLE cycle does not accept a pointer op until T+2).
- Invariant: bufp and fieldp never both change in one cycle. A swap never preempts an accepted READ/WRITE; it waits for IDLE.
- Illegal op (6/7): accepted, err<=1, no other effect.
- NOP: accepted, no effect.
- swap_req deasserted before ack: the request is dropped, no ack.

Decomposition:
- Shared package patbuf_pkg: op encoding constants (OP_NOP..OP_SELBUF), state enum, BUF_COUNT/BUFFER_SIZE/BUFFER_WIDTH defaults and derived pointer widths.
- A single flat module; no sub-module warranted (FSM plus pointer registers).

Test Plan:
- Reset: drive garbage, rst=1 one cycle -> bufp=0, fieldp=0, all strobes 0, err=0.
- SEEK 31, NEXT -> fieldp 31 then 0 (wrap); READ with field_byte=0xA5 -> rsp_valid pulse 2 cycles after accept, rsp_data=0xA5.
- WRITE 0x3C at fieldp=7 -> field_write high exactly one cycle, field_in=0x3C, fieldp stays 7 through the write; cmd_ready low until 2 cycles after accept.
- swap_req (swap_buf=5) and cmd_valid SEEK 9 in the same IDLE cycle -> bufp=5 with swap_ack first, SETTLE cycle, SEEK accepted afterwards; fieldp=9 changes in a later cycle than bufp.
- swap_req raised during READ -> ack only after rsp_valid; monitor asserts bufp/fieldp never change in the same cycle across 1000 random commands.
- Op 7 accepted -> err=1 and stays 1 until rst; pointers unchanged.
